// File: rtl/wb_pkg.sv
// Shared writeback definitions: arbiter state encoding, queued result record,
// and default widths used by both the writeback path and the register file.
package wb_pkg;

    // Register file geometry shared with the register file itself.
    localparam int WB_WIDTH      = 5;
    localparam int WB_DWIDTH     = 32;

    // Default queue depth and fairness bound for the load/multi-cycle path.
    localparam int WB_DEPTH      = 2;
    localparam int WB_STARVE_MAX = 3;

    // Arbiter states: NORMAL lets the ALU win, DRAIN forces one queued write.
    typedef enum logic [0:0] {
        NORMAL = 1'b0,
        DRAIN  = 1'b1
    } wb_state_e;

    // One queued writeback at the default register file geometry.
    typedef struct packed {
        logic [WB_WIDTH-1:0]  rd;
        logic [WB_DWIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Result queue for variable-latency writebacks: circular storage with wrap-bit
// pointers, occupancy, and a two-port youngest-match forwarding search over all
// live entries.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int WIDTH  = WB_WIDTH,
    parameter int DWIDTH = WB_DWIDTH,
    parameter int DEPTH  = WB_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_push,
    input  logic [WIDTH-1:0]        i_push_rd,
    input  logic [DWIDTH-1:0]       i_push_data,
    input  logic                    i_pop,
    output logic [WIDTH-1:0]        o_head_rd,
    output logic [DWIDTH-1:0]       o_head_data,
    output logic                    o_empty,
    output logic                    o_full,
    output logic [$clog2(DEPTH):0]  o_count,
    input  logic [WIDTH-1:0]        i_fwd_addr_a,
    input  logic [WIDTH-1:0]        i_fwd_addr_b,
    output logic                    o_fwd_hit_a,
    output logic                    o_fwd_hit_b,
    output logic [DWIDTH-1:0]       o_fwd_data_a,
    output logic [DWIDTH-1:0]       o_fwd_data_b
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Storage is plain registers: forwarding needs every entry visible at once.
    logic [WIDTH-1:0]  r_rd_mem   [DEPTH];
    logic [DWIDTH-1:0] r_data_mem [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [CW-1:0]     r_wr_ptr;
    logic [CW-1:0]     r_rd_ptr;

    logic [CW-1:0]     w_count;
    logic              w_push_ok;
    logic              w_pop_ok;
    logic [DEPTH-1:0]  w_slot_valid;
    logic [WIDTH-1:0]  w_fwd_addr [2];

    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign o_count   = w_count;
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (w_count == CW'(DEPTH));

    // Guard both sides so a misbehaving caller cannot corrupt the pointers.
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    assign o_head_rd   = r_rd_mem[r_rd_ptr[AW-1:0]];
    assign o_head_data = r_data_mem[r_rd_ptr[AW-1:0]];

    // Advance write/read pointers on accepted push/pop; reset empties the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + CW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + CW'(1);
            end
        end
    end

    // Write the pushed record into the slot addressed by the write pointer.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_rd_mem[r_wr_ptr[AW-1:0]]   <= i_push_rd;
            r_data_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        end
    end

    // A slot is live when its age behind the head is below the occupancy.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [AW-1:0] w_age;
            assign w_age            = AW'(gi) - r_rd_ptr[AW-1:0];
            assign w_slot_valid[gi] = ({1'b0, w_age} < w_count);
        end
    endgenerate

    assign w_fwd_addr[0] = i_fwd_addr_a;
    assign w_fwd_addr[1] = i_fwd_addr_b;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic              w_hit;
            logic [DWIDTH-1:0] w_data;
            logic [AW-1:0]     w_idx;

            // Walk entries oldest to youngest so the last match seen is the youngest.
            always_comb begin
                w_hit  = 1'b0;
                w_data = '0;
                w_idx  = '0;
                for (int k = 0; k < DEPTH; k++) begin
                    w_idx = r_rd_ptr[AW-1:0] + AW'(k);
                    if (w_slot_valid[w_idx] && (w_fwd_addr[gi] != '0) &&
                        (r_rd_mem[w_idx] == w_fwd_addr[gi])) begin
                        w_hit  = 1'b1;
                        w_data = r_data_mem[w_idx];
                    end
                end
            end
        end
    endgenerate

    assign o_fwd_hit_a  = g_fwd[0].w_hit;
    assign o_fwd_data_a = g_fwd[0].w_data;
    assign o_fwd_hit_b  = g_fwd[1].w_hit;
    assign o_fwd_data_b = g_fwd[1].w_data;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results with queued load/multi-cycle
// results onto the register file's single write port. The ALU normally wins; a
// bounded starvation counter forces a one-cycle DRAIN so the queue always moves.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int WIDTH      = WB_WIDTH,
    parameter int DWIDTH     = WB_DWIDTH,
    parameter int DEPTH      = WB_DEPTH,
    parameter int STARVE_MAX = WB_STARVE_MAX
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    alu_valid,
    input  logic [WIDTH-1:0]        alu_rd,
    input  logic [DWIDTH-1:0]       alu_data,
    output logic                    alu_stall,
    input  logic                    lsu_valid,
    output logic                    lsu_ready,
    input  logic [WIDTH-1:0]        lsu_rd,
    input  logic [DWIDTH-1:0]       lsu_data,
    output logic                    RegWEn,
    output logic [WIDTH-1:0]        AddrD,
    output logic [DWIDTH-1:0]       DataD,
    input  logic [WIDTH-1:0]        fwd_addr_a,
    input  logic [WIDTH-1:0]        fwd_addr_b,
    output logic                    fwd_hit_a,
    output logic                    fwd_hit_b,
    output logic [DWIDTH-1:0]       fwd_data_a,
    output logic [DWIDTH-1:0]       fwd_data_b,
    output logic [$clog2(DEPTH):0]  pending
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    wb_state_e          r_state;
    logic [SW-1:0]      r_starve_cnt;
    logic               r_alu_stall;
    logic               r_wen;
    logic [WIDTH-1:0]   r_addr;
    logic [DWIDTH-1:0]  r_data;

    logic               w_empty;
    logic               w_full;
    logic [CW-1:0]      w_count;
    logic [WIDTH-1:0]   w_head_rd;
    logic [DWIDTH-1:0]  w_head_data;
    logic               w_push;
    logic               w_pop;
    logic               w_alu_req;
    logic               w_sel_alu;
    logic               w_starve_limit;

    // Ready comes from registered occupancy only, never from this cycle's pop.
    assign lsu_ready = !w_full;

    // Zero-destination transfers handshake normally but are dropped here.
    assign w_push    = lsu_valid && lsu_ready && (lsu_rd != '0);

    // The ALU counts as a requester only with a real destination and no stall.
    assign w_alu_req = alu_valid && (alu_rd != '0) && !r_alu_stall;

    // One more ALU win over a waiting queue reaches the starvation bound.
    assign w_starve_limit = (r_starve_cnt == SW'(STARVE_MAX - 1));

    wb_fifo #(
        .WIDTH  (WIDTH),
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (w_push),
        .i_push_rd    (lsu_rd),
        .i_push_data  (lsu_data),
        .i_pop        (w_pop),
        .o_head_rd    (w_head_rd),
        .o_head_data  (w_head_data),
        .o_empty      (w_empty),
        .o_full       (w_full),
        .o_count      (w_count),
        .i_fwd_addr_a (fwd_addr_a),
        .i_fwd_addr_b (fwd_addr_b),
        .o_fwd_hit_a  (fwd_hit_a),
        .o_fwd_hit_b  (fwd_hit_b),
        .o_fwd_data_a (fwd_data_a),
        .o_fwd_data_b (fwd_data_b)
    );

    // Pick this cycle's writer: DRAIN forces the queue head, else ALU then queue.
    always_comb begin
        w_sel_alu = 1'b0;
        w_pop     = 1'b0;
        if (r_state == DRAIN) begin
            w_pop = !w_empty;
        end else if (w_alu_req) begin
            w_sel_alu = 1'b1;
        end else begin
            w_pop = !w_empty;
        end
    end

    // Arbitration FSM with registered write port, stall flag and starvation count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= NORMAL;
            r_starve_cnt <= '0;
            r_alu_stall  <= 1'b0;
            r_wen        <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
        end else begin
            case (r_state)
                NORMAL: begin
                    if (w_sel_alu) begin
                        r_wen  <= 1'b1;
                        r_addr <= alu_rd;
                        r_data <= alu_data;
                        // Only count wins that actually kept a queued result waiting.
                        if (!w_empty) begin
                            r_starve_cnt <= r_starve_cnt + SW'(1);
                            if (w_starve_limit) begin
                                r_state     <= DRAIN;
                                r_alu_stall <= 1'b1;
                            end
                        end
                    end else if (w_pop) begin
                        r_wen        <= 1'b1;
                        r_addr       <= w_head_rd;
                        r_data       <= w_head_data;
                        r_starve_cnt <= '0;
                    end else begin
                        r_wen <= 1'b0;
                    end
                end
                DRAIN: begin
                    // Exactly one forced queue write, then the ALU may compete again.
                    r_state      <= NORMAL;
                    r_alu_stall  <= 1'b0;
                    r_starve_cnt <= '0;
                    if (w_pop) begin
                        r_wen  <= 1'b1;
                        r_addr <= w_head_rd;
                        r_data <= w_head_data;
                    end else begin
                        r_wen <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= NORMAL;
                    r_alu_stall <= 1'b0;
                    r_wen       <= 1'b0;
                end
            endcase
        end
    end

    assign alu_stall = r_alu_stall;
    assign RegWEn    = r_wen;
    assign AddrD     = r_addr;
    assign DataD     = r_data;
    assign pending   = w_count;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, randomized run against a queue
// model, and an asynchronous reset taken in the middle of a forced drain.
module tb_wb_arbiter;

    localparam int WIDTH      = 5;
    localparam int DWIDTH     = 32;
    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 3;
    localparam int CW         = $clog2(DEPTH) + 1;
    localparam int NV         = 13;
    localparam int NRAND      = 500;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              alu_valid = 1'b0;
    logic [WIDTH-1:0]  alu_rd = '0;
    logic [DWIDTH-1:0] alu_data = '0;
    logic              alu_stall;
    logic              lsu_valid = 1'b0;
    logic              lsu_ready;
    logic [WIDTH-1:0]  lsu_rd = '0;
    logic [DWIDTH-1:0] lsu_data = '0;
    logic              RegWEn;
    logic [WIDTH-1:0]  AddrD;
    logic [DWIDTH-1:0] DataD;
    logic [WIDTH-1:0]  fwd_addr_a = '0;
    logic [WIDTH-1:0]  fwd_addr_b = '0;
    logic              fwd_hit_a;
    logic              fwd_hit_b;
    logic [DWIDTH-1:0] fwd_data_a;
    logic [DWIDTH-1:0] fwd_data_b;
    logic [CW-1:0]     pending;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_arbiter #(
        .WIDTH      (WIDTH),
        .DWIDTH     (DWIDTH),
        .DEPTH      (DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .alu_stall  (alu_stall),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_rd     (lsu_rd),
        .lsu_data   (lsu_data),
        .RegWEn     (RegWEn),
        .AddrD      (AddrD),
        .DataD      (DataD),
        .fwd_addr_a (fwd_addr_a),
        .fwd_addr_b (fwd_addr_b),
        .fwd_hit_a  (fwd_hit_a),
        .fwd_hit_b  (fwd_hit_b),
        .fwd_data_a (fwd_data_a),
        .fwd_data_b (fwd_data_b),
        .pending    (pending)
    );

    // Directed vector: inputs for one cycle and the outputs expected after its edge.
    typedef struct {
        logic              av;
        logic [WIDTH-1:0]  ard;
        logic [DWIDTH-1:0] adata;
        logic              lv;
        logic [WIDTH-1:0]  lrd;
        logic [DWIDTH-1:0] ldata;
        logic [WIDTH-1:0]  fa;
        logic [WIDTH-1:0]  fb;
        logic              wen;
        logic [WIDTH-1:0]  addr;
        logic [DWIDTH-1:0] data;
        int                pend;
        logic              ready;
        logic              stall;
        logic              ha;
        logic [DWIDTH-1:0] da;
        logic              hb;
        logic [DWIDTH-1:0] db;
    } vec_t;

    vec_t vecs [NV];

    // Reference model: queued results as a plain queue plus a count of how
    // many cycles the oldest result has been passed over.
    typedef struct {
        logic [WIDTH-1:0]  rd;
        logic [DWIDTH-1:0] data;
    } ent_t;

    ent_t              mq [$];
    int                m_skips;
    bit                m_forced;
    logic              m_wen;
    logic [WIDTH-1:0]  m_addr;
    logic [DWIDTH-1:0] m_data;

    function automatic vec_t mk(
        input logic av, input logic [WIDTH-1:0] ard, input logic [DWIDTH-1:0] adata,
        input logic lv, input logic [WIDTH-1:0] lrd, input logic [DWIDTH-1:0] ldata,
        input logic [WIDTH-1:0] fa, input logic [WIDTH-1:0] fb,
        input logic wen, input logic [WIDTH-1:0] addr, input logic [DWIDTH-1:0] data,
        input int pend, input logic ready, input logic stall,
        input logic ha, input logic [DWIDTH-1:0] da,
        input logic hb, input logic [DWIDTH-1:0] db);
        vec_t v;
        v.av = av; v.ard = ard; v.adata = adata;
        v.lv = lv; v.lrd = lrd; v.ldata = ldata;
        v.fa = fa; v.fb = fb;
        v.wen = wen; v.addr = addr; v.data = data;
        v.pend = pend; v.ready = ready; v.stall = stall;
        v.ha = ha; v.da = da; v.hb = hb; v.db = db;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic wen, input logic [WIDTH-1:0] addr,
                             input logic [DWIDTH-1:0] data, input int pend, input logic ready,
                             input logic stall, input logic ha, input logic [DWIDTH-1:0] da,
                             input logic hb, input logic [DWIDTH-1:0] db);
        chk({tag, "_wen"},    32'(RegWEn),     32'(wen));
        chk({tag, "_addr"},   32'(AddrD),      32'(addr));
        chk({tag, "_data"},   DataD,           data);
        chk({tag, "_pend"},   32'(pending),    32'(pend));
        chk({tag, "_ready"},  32'(lsu_ready),  32'(ready));
        chk({tag, "_stall"},  32'(alu_stall),  32'(stall));
        chk({tag, "_hit_a"},  32'(fwd_hit_a),  32'(ha));
        chk({tag, "_fdat_a"}, fwd_data_a,      da);
        chk({tag, "_hit_b"},  32'(fwd_hit_b),  32'(hb));
        chk({tag, "_fdat_b"}, fwd_data_b,      db);
    endtask

    task automatic drive(input logic av, input logic [WIDTH-1:0] ard, input logic [DWIDTH-1:0] adata,
                         input logic lv, input logic [WIDTH-1:0] lrd, input logic [DWIDTH-1:0] ldata,
                         input logic [WIDTH-1:0] fa, input logic [WIDTH-1:0] fb);
        alu_valid  = av;
        alu_rd     = ard;
        alu_data   = adata;
        lsu_valid  = lv;
        lsu_rd     = lrd;
        lsu_data   = ldata;
        fwd_addr_a = fa;
        fwd_addr_b = fb;
    endtask

    // Hold reset across two edges, then release just after an edge.
    task automatic do_reset();
        drive(1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Youngest queued entry with a matching nonzero destination.
    function automatic void model_fwd(input logic [WIDTH-1:0] a, output logic hit,
                                      output logic [DWIDTH-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (a != '0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].rd == a) begin
                    hit = 1'b1;
                    d   = mq[i].data;
                    break;
                end
            end
        end
    endfunction

    // One clock of the model: who writes this cycle, then what enters the queue.
    task automatic model_step(input logic av, input logic [WIDTH-1:0] ard, input logic [DWIDTH-1:0] adata,
                              input logic lv, input logic [WIDTH-1:0] lrd, input logic [DWIDTH-1:0] ldata);
        bit   can_accept;
        ent_t e;
        can_accept = (mq.size() < DEPTH);
        if (m_forced) begin
            // The oldest result has been skipped STARVE_MAX times: it goes now.
            e = mq.pop_front();
            m_wen = 1'b1; m_addr = e.rd; m_data = e.data;
            m_skips  = 0;
            m_forced = 1'b0;
        end else if (av && ard != '0) begin
            m_wen = 1'b1; m_addr = ard; m_data = adata;
            if (mq.size() > 0) begin
                m_skips++;
                if (m_skips >= STARVE_MAX) m_forced = 1'b1;
            end
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            m_wen = 1'b1; m_addr = e.rd; m_data = e.data;
            m_skips = 0;
        end else begin
            m_wen = 1'b0;
        end
        if (lv && can_accept && lrd != '0) begin
            e.rd   = lrd;
            e.data = ldata;
            mq.push_back(e);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time limit, expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        logic              av, lv, ha, hb;
        logic [WIDTH-1:0]  ard, lrd, fa, fb;
        logic [DWIDTH-1:0] adata, ldata, da, db;

        vecs[0]  = mk(1, 5, 32'h1234,     0, 0, 0,            5, 0,  1, 5,  32'h1234,     0, 1, 0, 0, 0,             0, 0);
        vecs[1]  = mk(0, 0, 0,            0, 0, 0,            0, 5,  0, 5,  32'h1234,     0, 1, 0, 0, 0,             0, 0);
        vecs[2]  = mk(0, 0, 0,            1, 3, 32'hFFFFFFFE, 3, 4,  0, 5,  32'h1234,     1, 1, 0, 1, 32'hFFFFFFFE, 0, 0);
        vecs[3]  = mk(0, 0, 0,            0, 0, 0,            3, 3,  1, 3,  32'hFFFFFFFE, 0, 1, 0, 0, 0,             0, 0);
        vecs[4]  = mk(1, 6, 32'h60,       1, 4, 32'hA,        4, 6,  1, 6,  32'h60,       1, 1, 0, 1, 32'hA,         0, 0);
        vecs[5]  = mk(1, 7, 32'h70,       1, 4, 32'hB,        4, 4,  1, 7,  32'h70,       2, 0, 0, 1, 32'hB,         1, 32'hB);
        vecs[6]  = mk(1, 8, 32'h80,       1, 9, 32'h99,       4, 9,  1, 8,  32'h80,       2, 0, 0, 1, 32'hB,         0, 0);
        vecs[7]  = mk(1, 9, 32'h90,       0, 0, 0,            4, 4,  1, 9,  32'h90,       2, 0, 1, 1, 32'hB,         1, 32'hB);
        vecs[8]  = mk(1, 10, 32'hA0,      0, 0, 0,            4, 2,  1, 4,  32'hA,        1, 1, 0, 1, 32'hB,         0, 0);
        vecs[9]  = mk(1, 10, 32'hA0,      0, 0, 0,            4, 10, 1, 10, 32'hA0,       1, 1, 0, 1, 32'hB,         0, 0);
        vecs[10] = mk(0, 0, 0,            0, 0, 0,            4, 4,  1, 4,  32'hB,        0, 1, 0, 0, 0,             0, 0);
        vecs[11] = mk(1, 0, 32'h55,       1, 0, 32'h66,       0, 0,  0, 4,  32'hB,        0, 1, 0, 0, 0,             0, 0);
        vecs[12] = mk(0, 0, 0,            0, 0, 0,            0, 0,  0, 4,  32'hB,        0, 1, 0, 0, 0,             0, 0);

        // Reset values, sampled while reset is still asserted.
        drive(1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all("reset", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        $display("reset: wen=%0d addr=%0d data=0x%08h pend=%0d", RegWEn, AddrD, DataD, pending);
        rst_n = 1'b1;

        // Directed table.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].av, vecs[i].ard, vecs[i].adata, vecs[i].lv, vecs[i].lrd,
                  vecs[i].ldata, vecs[i].fa, vecs[i].fb);
            @(posedge clk);
            #1;
            check_all($sformatf("v%0d", i), vecs[i].wen, vecs[i].addr, vecs[i].data,
                      vecs[i].pend, vecs[i].ready, vecs[i].stall, vecs[i].ha, vecs[i].da,
                      vecs[i].hb, vecs[i].db);
            $display("v%0d: wen=%0d addr=%0d data=0x%08h pend=%0d stall=%0d hit_a=%0d",
                     i, RegWEn, AddrD, DataD, pending, alu_stall, fwd_hit_a);
        end

        // Randomized traffic against the queue model.
        do_reset();
        mq.delete();
        m_skips = 0; m_forced = 1'b0;
        m_wen = 1'b0; m_addr = '0; m_data = '0;
        for (int c = 0; c < NRAND; c++) begin
            av    = ($urandom_range(0, 9) < 7);
            ard   = WIDTH'($urandom_range(0, 7));
            adata = $urandom;
            lv    = ($urandom_range(0, 9) < 5);
            lrd   = WIDTH'($urandom_range(0, 7));
            ldata = $urandom;
            fa    = WIDTH'($urandom_range(0, 7));
            fb    = WIDTH'($urandom_range(0, 7));
            drive(av, ard, adata, lv, lrd, ldata, fa, fb);
            model_step(av, ard, adata, lv, lrd, ldata);
            @(posedge clk);
            #1;
            model_fwd(fa, ha, da);
            model_fwd(fb, hb, db);
            check_all($sformatf("r%0d", c), m_wen, m_addr, m_data, mq.size(),
                      (mq.size() < DEPTH), m_forced, ha, da, hb, db);
            $display("r%0d: wen=%0d addr=%0d data=0x%08h pend=%0d stall=%0d",
                     c, RegWEn, AddrD, DataD, pending, alu_stall);
        end

        // Fill the queue, starve it into a drain, then reset mid-drain.
        do_reset();
        drive(1, 1, 32'h11, 1, 2, 32'h22, 2, 3);
        @(posedge clk); #1;
        chk("md_fill1_pend", 32'(pending), 32'd1);
        drive(1, 1, 32'h12, 1, 3, 32'h33, 2, 3);
        @(posedge clk); #1;
        chk("md_fill2_pend", 32'(pending), 32'd2);
        drive(1, 1, 32'h13, 0, 0, 0, 2, 3);
        @(posedge clk); #1;
        chk("md_pre_stall", 32'(alu_stall), 32'd0);
        drive(1, 1, 32'h14, 0, 0, 0, 2, 3);
        @(posedge clk); #1;
        check_all("md_drain", 1, 1, 32'h14, 2, 0, 1, 1, 32'h22, 1, 32'h33);
        $display("md_drain: stall=%0d pend=%0d", alu_stall, pending);
        drive(0, 0, 0, 0, 0, 0, 2, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("md_async", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        $display("md_async: wen=%0d pend=%0d stall=%0d", RegWEn, pending, alu_stall);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_all($sformatf("md_post%0d", i), 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
            $display("md_post%0d: wen=%0d pend=%0d", i, RegWEn, pending);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
